// File: rtl/lsu_lq_age.sv
// Age-ordered load queue: tracks loads from allocation to ROB retirement,
// replays missed loads oldest-first and flags loads hit by a retiring store.
module lsu_lq_age #(
  parameter int unsigned LQ_DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned TAG_WIDTH     = 6,
  parameter int unsigned MHQ_TAG_WIDTH = 2,
  localparam int unsigned SLOT_W       = $clog2(LQ_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [SLOT_W:0]          o_count,
  input  logic                     i_alloc_en,
  input  logic [TAG_WIDTH-1:0]     i_alloc_tag,
  input  logic [ADDR_WIDTH-1:0]    i_alloc_addr,
  input  logic [1:0]               i_alloc_size,
  output logic [SLOT_W-1:0]        o_alloc_slot,
  output logic                     o_replay_valid,
  input  logic                     i_replay_ready,
  output logic [SLOT_W-1:0]        o_replay_slot,
  output logic [TAG_WIDTH-1:0]     o_replay_tag,
  output logic [ADDR_WIDTH-1:0]    o_replay_addr,
  output logic [1:0]               o_replay_size,
  input  logic                     i_update_en,
  input  logic [SLOT_W-1:0]        i_update_slot,
  input  logic                     i_update_retry,
  input  logic [MHQ_TAG_WIDTH-1:0] i_update_mhq_tag,
  input  logic                     i_mhq_fill_en,
  input  logic [MHQ_TAG_WIDTH-1:0] i_mhq_fill_tag,
  input  logic                     i_sq_retire_en,
  input  logic [ADDR_WIDTH-1:0]    i_sq_retire_addr,
  input  logic [1:0]               i_sq_retire_size,
  input  logic                     i_rob_retire_en,
  input  logic [TAG_WIDTH-1:0]     i_rob_retire_tag,
  output logic                     o_rob_retire_mis_speculated
);

  logic [LQ_DEPTH-1:0]      valid_q, valid_d;
  logic [LQ_DEPTH-1:0]      needs_q, needs_d;
  logic [LQ_DEPTH-1:0]      rdy_q, rdy_d;
  logic [LQ_DEPTH-1:0]      retry_q, retry_d;
  logic [LQ_DEPTH-1:0]      mis_q, mis_d;
  logic [ADDR_WIDTH-1:0]    addr_q [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0]    addr_d [LQ_DEPTH];
  logic [1:0]               size_q [LQ_DEPTH];
  logic [1:0]               size_d [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]     tag_q  [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]     tag_d  [LQ_DEPTH];
  logic [MHQ_TAG_WIDTH-1:0] mhq_q  [LQ_DEPTH];
  logic [MHQ_TAG_WIDTH-1:0] mhq_d  [LQ_DEPTH];
  // older_q[j][k] set means entry j was allocated before entry k.
  logic [LQ_DEPTH-1:0]      older_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]      older_d [LQ_DEPTH];
  logic                     hold_q, hold_d;
  logic [SLOT_W-1:0]        hold_slot_q, hold_slot_d;

  logic [LQ_DEPTH-1:0]      ready, is_oldest, st_ovl, ret_match;
  logic [SLOT_W-1:0]        oldest_slot, sel_slot, free_slot;
  logic [SLOT_W:0]          count;
  logic                     rep_valid, alloc_fire, xfer;

  // Half-open byte ranges compared with one extra bit so the top of memory does not wrap.
  function automatic logic overlaps(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] s,
                                    input logic [ADDR_WIDTH-1:0] b, input logic [1:0] t);
    logic [ADDR_WIDTH:0] one, a_end, b_end;
    one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    a_end = {1'b0, a} + (one << s);
    b_end = {1'b0, b} + (one << t);
    return ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
  endfunction

  always_comb begin
    ready       = valid_q & rdy_q;
    is_oldest   = '0;
    oldest_slot = '0;
    free_slot   = '0;
    count       = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      logic [LQ_DEPTH-1:0] col;
      col = '0;
      for (int unsigned j = 0; j < LQ_DEPTH; j++) col[j] = older_q[j][i];
      is_oldest[i] = ready[i] && ((ready & col) == '0);
      count = count + {{SLOT_W{1'b0}}, valid_q[i]};
    end
    for (int unsigned i = LQ_DEPTH; i > 0; i--) begin
      if (is_oldest[i-1]) oldest_slot = SLOT_W'(i-1);
      if (!valid_q[i-1])  free_slot   = SLOT_W'(i-1);
    end
    // A stalled presentation keeps its slot even if an older load wakes meanwhile.
    sel_slot  = (hold_q && ready[hold_slot_q]) ? hold_slot_q : oldest_slot;
    rep_valid = |ready;

    st_ovl    = '0;
    ret_match = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      st_ovl[i]    = i_sq_retire_en && valid_q[i] &&
                     overlaps(addr_q[i], size_q[i], i_sq_retire_addr, i_sq_retire_size);
      ret_match[i] = i_rob_retire_en && valid_q[i] && (tag_q[i] == i_rob_retire_tag);
    end
  end

  assign o_full         = &valid_q;
  assign o_empty        = ~|valid_q;
  assign o_count        = count;
  assign o_alloc_slot   = free_slot;
  assign o_replay_valid = rep_valid;
  assign o_replay_slot  = rep_valid ? sel_slot : '0;
  assign o_replay_tag   = rep_valid ? tag_q[sel_slot]  : '0;
  assign o_replay_addr  = rep_valid ? addr_q[sel_slot] : '0;
  assign o_replay_size  = rep_valid ? size_q[sel_slot] : '0;
  assign o_rob_retire_mis_speculated = |(ret_match & (mis_q | st_ovl));

  assign alloc_fire = i_alloc_en && !o_full;
  assign xfer       = rep_valid && i_replay_ready;

  always_comb begin
    valid_d     = valid_q;
    needs_d     = needs_q;
    rdy_d       = rdy_q;
    retry_d     = retry_q;
    mis_d       = mis_q;
    addr_d      = addr_q;
    size_d      = size_q;
    tag_d       = tag_q;
    mhq_d       = mhq_q;
    older_d     = older_q;
    hold_d      = rep_valid && !i_replay_ready;
    hold_slot_d = sel_slot;

    // Order matters: fill wakeup, then replay transfer, then update, then retire.
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (st_ovl[i]) mis_d[i] = 1'b1;
      if (i_mhq_fill_en && needs_q[i] && (retry_q[i] || (mhq_q[i] == i_mhq_fill_tag)))
        rdy_d[i] = 1'b1;
      if (xfer && (sel_slot == SLOT_W'(i))) begin
        rdy_d[i]   = 1'b0;
        needs_d[i] = 1'b0;
      end
      if (i_update_en && valid_q[i] && (i_update_slot == SLOT_W'(i))) begin
        needs_d[i] = 1'b1;
        retry_d[i] = i_update_retry;
        mhq_d[i]   = i_update_mhq_tag;
        rdy_d[i]   = i_mhq_fill_en && (i_update_retry || (i_update_mhq_tag == i_mhq_fill_tag));
      end
      if (ret_match[i]) begin
        valid_d[i] = 1'b0;
        needs_d[i] = 1'b0;
        rdy_d[i]   = 1'b0;
        mis_d[i]   = 1'b0;
      end
    end

    if (alloc_fire) begin
      valid_d[free_slot] = 1'b1;
      addr_d[free_slot]  = i_alloc_addr;
      size_d[free_slot]  = i_alloc_size;
      tag_d[free_slot]   = i_alloc_tag;
      needs_d[free_slot] = 1'b0;
      rdy_d[free_slot]   = 1'b0;
      mis_d[free_slot]   = 1'b0;
      for (int unsigned j = 0; j < LQ_DEPTH; j++) older_d[j][free_slot] = valid_q[j];
      older_d[free_slot] = '0;
    end

    if (i_flush) begin
      valid_d = '0;
      needs_d = '0;
      rdy_d   = '0;
      mis_d   = '0;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      needs_q     <= '0;
      rdy_q       <= '0;
      retry_q     <= '0;
      mis_q       <= '0;
      addr_q      <= '{default: '0};
      size_q      <= '{default: '0};
      tag_q       <= '{default: '0};
      mhq_q       <= '{default: '0};
      older_q     <= '{default: '0};
      hold_q      <= 1'b0;
      hold_slot_q <= '0;
    end else begin
      valid_q     <= valid_d;
      needs_q     <= needs_d;
      rdy_q       <= rdy_d;
      retry_q     <= retry_d;
      mis_q       <= mis_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      tag_q       <= tag_d;
      mhq_q       <= mhq_d;
      older_q     <= older_d;
      hold_q      <= hold_d;
      hold_slot_q <= hold_slot_d;
    end
  end

endmodule

// File: tb/tb_lsu_lq_age.sv
// Bench for lsu_lq_age: directed scenarios with literal expectations plus a
// randomized run checked each cycle against an allocation-order queue model.
module tb_lsu_lq_age;
  localparam int D  = 8;
  localparam int AW = 32;
  localparam int TW = 6;
  localparam int MW = 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_flush;
  logic          o_full, o_empty;
  logic [SW:0]   o_count;
  logic          i_alloc_en;
  logic [TW-1:0] i_alloc_tag;
  logic [AW-1:0] i_alloc_addr;
  logic [1:0]    i_alloc_size;
  logic [SW-1:0] o_alloc_slot;
  logic          o_replay_valid, i_replay_ready;
  logic [SW-1:0] o_replay_slot;
  logic [TW-1:0] o_replay_tag;
  logic [AW-1:0] o_replay_addr;
  logic [1:0]    o_replay_size;
  logic          i_update_en;
  logic [SW-1:0] i_update_slot;
  logic          i_update_retry;
  logic [MW-1:0] i_update_mhq_tag;
  logic          i_mhq_fill_en;
  logic [MW-1:0] i_mhq_fill_tag;
  logic          i_sq_retire_en;
  logic [AW-1:0] i_sq_retire_addr;
  logic [1:0]    i_sq_retire_size;
  logic          i_rob_retire_en;
  logic [TW-1:0] i_rob_retire_tag;
  logic          o_rob_retire_mis_speculated;

  lsu_lq_age #(.LQ_DEPTH(D), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MHQ_TAG_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .i_alloc_en(i_alloc_en), .i_alloc_tag(i_alloc_tag), .i_alloc_addr(i_alloc_addr),
    .i_alloc_size(i_alloc_size), .o_alloc_slot(o_alloc_slot),
    .o_replay_valid(o_replay_valid), .i_replay_ready(i_replay_ready),
    .o_replay_slot(o_replay_slot), .o_replay_tag(o_replay_tag),
    .o_replay_addr(o_replay_addr), .o_replay_size(o_replay_size),
    .i_update_en(i_update_en), .i_update_slot(i_update_slot),
    .i_update_retry(i_update_retry), .i_update_mhq_tag(i_update_mhq_tag),
    .i_mhq_fill_en(i_mhq_fill_en), .i_mhq_fill_tag(i_mhq_fill_tag),
    .i_sq_retire_en(i_sq_retire_en), .i_sq_retire_addr(i_sq_retire_addr),
    .i_sq_retire_size(i_sq_retire_size),
    .i_rob_retire_en(i_rob_retire_en), .i_rob_retire_tag(i_rob_retire_tag),
    .o_rob_retire_mis_speculated(o_rob_retire_mis_speculated)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: entries carry an allocation sequence number; oldest = smallest number.
  bit            m_valid [D];
  bit            m_needs [D];
  bit            m_rdy   [D];
  bit            m_retry [D];
  bit            m_mis   [D];
  logic [AW-1:0] m_addr  [D];
  logic [1:0]    m_size  [D];
  logic [TW-1:0] m_tag   [D];
  logic [MW-1:0] m_mhq   [D];
  longint        m_seq   [D];
  longint        seq_ctr;
  bit            m_hold;
  int            m_hold_slot;
  logic [TW-1:0] tag_ctr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ovl(input logic [AW-1:0] a, input logic [1:0] s,
                               input logic [AW-1:0] b, input logic [1:0] t);
    longint unsigned la, lb;
    la = longint'(a);
    lb = longint'(b);
    return (la < lb + (longint'(1) << t)) && (lb < la + (longint'(1) << s));
  endfunction

  function automatic int model_best();
    int b = -1;
    if (m_hold && m_valid[m_hold_slot] && m_rdy[m_hold_slot]) return m_hold_slot;
    for (int i = 0; i < D; i++)
      if (m_valid[i] && m_rdy[i] && (b < 0 || m_seq[i] < m_seq[b])) b = i;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 0; m_needs[i] = 0; m_rdy[i] = 0; m_retry[i] = 0; m_mis[i] = 0;
      m_addr[i] = '0; m_size[i] = '0; m_tag[i] = '0; m_mhq[i] = '0; m_seq[i] = 0;
    end
    m_hold = 0;
    m_hold_slot = 0;
  endtask

  task automatic compare();
    int cnt = 0;
    int free = -1;
    int best;
    bit rm = 0;
    for (int i = 0; i < D; i++) begin
      if (m_valid[i]) cnt++;
      else if (free < 0) free = i;
    end
    best = model_best();
    chk("count", 64'(o_count), 64'(cnt));
    chk("full", 64'(o_full), 64'(cnt == D));
    chk("empty", 64'(o_empty), 64'(cnt == 0));
    chk("alloc_slot", 64'(o_alloc_slot), 64'(free < 0 ? 0 : free));
    chk("replay_valid", 64'(o_replay_valid), 64'(best >= 0));
    chk("replay_slot", 64'(o_replay_slot), 64'(best >= 0 ? best : 0));
    chk("replay_tag", 64'(o_replay_tag), best >= 0 ? 64'(m_tag[best]) : 64'd0);
    chk("replay_addr", 64'(o_replay_addr), best >= 0 ? 64'(m_addr[best]) : 64'd0);
    chk("replay_size", 64'(o_replay_size), best >= 0 ? 64'(m_size[best]) : 64'd0);
    for (int i = 0; i < D; i++)
      if (i_rob_retire_en && m_valid[i] && m_tag[i] == i_rob_retire_tag &&
          (m_mis[i] || (i_sq_retire_en && m_ovl(m_addr[i], m_size[i], i_sq_retire_addr, i_sq_retire_size))))
        rm = 1;
    chk("retire_mis", 64'(o_rob_retire_mis_speculated), 64'(rm));
  endtask

  task automatic model_step();
    int best, free;
    bit n_valid[D], n_needs[D], n_rdy[D], n_retry[D], n_mis[D];
    logic [MW-1:0] n_mhq[D];
    best = model_best();
    free = -1;
    for (int i = D - 1; i >= 0; i--) if (!m_valid[i]) free = i;
    if (i_flush) begin
      for (int i = 0; i < D; i++) begin
        m_valid[i] = 0; m_needs[i] = 0; m_rdy[i] = 0; m_mis[i] = 0;
      end
      m_hold = 0;
      return;
    end
    n_valid = m_valid; n_needs = m_needs; n_rdy = m_rdy;
    n_retry = m_retry; n_mis = m_mis; n_mhq = m_mhq;
    for (int i = 0; i < D; i++) begin
      if (i_sq_retire_en && m_valid[i] &&
          m_ovl(m_addr[i], m_size[i], i_sq_retire_addr, i_sq_retire_size)) n_mis[i] = 1;
      if (i_mhq_fill_en && m_needs[i] && (m_retry[i] || m_mhq[i] == i_mhq_fill_tag)) n_rdy[i] = 1;
      if (best == i && i_replay_ready) begin n_rdy[i] = 0; n_needs[i] = 0; end
      if (i_update_en && m_valid[i] && int'(i_update_slot) == i) begin
        n_needs[i] = 1;
        n_retry[i] = i_update_retry;
        n_mhq[i]   = i_update_mhq_tag;
        n_rdy[i]   = i_mhq_fill_en && (i_update_retry || i_update_mhq_tag == i_mhq_fill_tag);
      end
      if (i_rob_retire_en && m_valid[i] && m_tag[i] == i_rob_retire_tag) begin
        n_valid[i] = 0; n_needs[i] = 0; n_rdy[i] = 0; n_mis[i] = 0;
      end
    end
    if (i_alloc_en && free >= 0) begin
      n_valid[free] = 1; n_needs[free] = 0; n_rdy[free] = 0; n_mis[free] = 0;
      m_addr[free] = i_alloc_addr;
      m_size[free] = i_alloc_size;
      m_tag[free]  = i_alloc_tag;
      m_seq[free]  = seq_ctr;
      seq_ctr++;
    end
    m_valid = n_valid; m_needs = n_needs; m_rdy = n_rdy;
    m_retry = n_retry; m_mis = n_mis; m_mhq = n_mhq;
    m_hold      = (best >= 0) && !i_replay_ready;
    m_hold_slot = (best >= 0) ? best : 0;
  endtask

  task automatic clr();
    i_flush = 0; i_alloc_en = 0; i_alloc_tag = '0; i_alloc_addr = '0; i_alloc_size = '0;
    i_replay_ready = 0; i_update_en = 0; i_update_slot = '0; i_update_retry = 0;
    i_update_mhq_tag = '0; i_mhq_fill_en = 0; i_mhq_fill_tag = '0;
    i_sq_retire_en = 0; i_sq_retire_addr = '0; i_sq_retire_size = '0;
    i_rob_retire_en = 0; i_rob_retire_tag = '0;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask

  task automatic alloc(input int tag, input logic [AW-1:0] addr, input logic [1:0] size);
    clr();
    i_alloc_en = 1; i_alloc_tag = TW'(tag); i_alloc_addr = addr; i_alloc_size = size;
    cycle();
  endtask

  function automatic logic [TW-1:0] fresh_tag();
    bit used;
    for (int n = 0; n < 64; n++) begin
      tag_ctr = tag_ctr + 1'b1;
      used = 0;
      for (int i = 0; i < D; i++) if (m_valid[i] && m_tag[i] == tag_ctr) used = 1;
      if (!used) break;
    end
    return tag_ctr;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8 + $urandom_range(0, 7);
    return 32'h0000_0100 + $urandom_range(0, 31);
  endfunction

  initial begin
    int s;
    clr();
    model_reset();
    seq_ctr = 0;
    tag_ctr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_alloc_slot", 64'(o_alloc_slot), 64'd0);
    chk("rst_replay_valid", 64'(o_replay_valid), 64'd0);
    chk("rst_retire_mis", 64'(o_rob_retire_mis_speculated), 64'd0);
    rst = 0;

    // Fill to capacity, drop a ninth, retire tag 3.
    for (int i = 0; i < 8; i++) alloc(i + 1, 32'h1000 + 32'(16 * i), 2'd2);
    clr();
    chk("full_after_8", 64'(o_full), 64'd1);
    alloc(9, 32'h2000, 2'd0);
    clr();
    chk("count_after_drop", 64'(o_count), 64'd8);
    i_rob_retire_en = 1; i_rob_retire_tag = 6'd3;
    cycle();
    clr();
    chk("full_after_ret", 64'(o_full), 64'd0);
    chk("count_after_ret", 64'(o_count), 64'd7);
    chk("slot_after_ret", 64'(o_alloc_slot), 64'd2);

    // Age order beats slot order.
    i_flush = 1;
    cycle();
    clr();
    chk("slot_A", 64'(o_alloc_slot), 64'd0);
    alloc(5, 32'h0000_0300, 2'd2);
    alloc(6, 32'h0000_0310, 2'd1);
    clr(); i_rob_retire_en = 1; i_rob_retire_tag = 6'd5;
    cycle();
    clr();
    chk("slot_C", 64'(o_alloc_slot), 64'd0);
    alloc(7, 32'h0000_0320, 2'd0);
    for (int i = 1; i >= 0; i--) begin
      clr(); i_update_en = 1; i_update_slot = SW'(i); i_update_mhq_tag = 2'd1;
      cycle();
    end
    clr(); i_mhq_fill_en = 1; i_mhq_fill_tag = 2'd1;
    cycle();
    clr();
    chk("first_replay_slot", 64'(o_replay_slot), 64'd1);
    chk("first_replay_tag", 64'(o_replay_tag), 64'd6);
    i_replay_ready = 1;
    cycle();
    clr();
    chk("second_replay_slot", 64'(o_replay_slot), 64'd0);
    chk("second_replay_tag", 64'(o_replay_tag), 64'd7);
    i_replay_ready = 1;
    cycle();
    clr();
    chk("replays_drained", 64'(o_replay_valid), 64'd0);

    // Same-cycle update and fill, then a stalled handshake.
    alloc(8, 32'h0000_0200, 2'd3);
    clr(); i_update_en = 1; i_update_slot = 3'd2; i_update_mhq_tag = 2'd3;
    i_mhq_fill_en = 1; i_mhq_fill_tag = 2'd3;
    cycle();
    clr();
    chk("wakeup_valid", 64'(o_replay_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      clr();
      chk("hold_slot", 64'(o_replay_slot), 64'd2);
      chk("hold_tag", 64'(o_replay_tag), 64'd8);
      chk("hold_addr", 64'(o_replay_addr), 64'h200);
      cycle();
    end
    clr(); i_replay_ready = 1;
    cycle();
    clr();
    chk("hold_released", 64'(o_replay_valid), 64'd0);

    // Byte-range overlap, including the top of the address space.
    i_flush = 1;
    cycle();
    alloc(10, 32'h0000_0102, 2'd1);
    alloc(11, 32'h0000_0104, 2'd0);
    alloc(12, 32'hFFFF_FFFF, 2'd0);
    clr(); i_sq_retire_en = 1; i_sq_retire_addr = 32'h0000_0100; i_sq_retire_size = 2'd2;
    cycle();
    clr(); i_sq_retire_en = 1; i_sq_retire_addr = 32'hFFFF_FFFE; i_sq_retire_size = 2'd2;
    cycle();
    clr(); i_rob_retire_en = 1; i_rob_retire_tag = 6'd10;
    #1 chk("mis_0x102", 64'(o_rob_retire_mis_speculated), 64'd1);
    cycle();
    clr(); i_rob_retire_en = 1; i_rob_retire_tag = 6'd11;
    #1 chk("mis_0x104", 64'(o_rob_retire_mis_speculated), 64'd0);
    cycle();
    clr(); i_rob_retire_en = 1; i_rob_retire_tag = 6'd12;
    #1 chk("mis_top", 64'(o_rob_retire_mis_speculated), 64'd1);
    cycle();
    alloc(13, 32'h0000_0100, 2'd2);
    clr(); i_rob_retire_en = 1; i_rob_retire_tag = 6'd13;
    i_sq_retire_en = 1; i_sq_retire_addr = 32'h0000_0100; i_sq_retire_size = 2'd0;
    #1 chk("mis_same_cycle", 64'(o_rob_retire_mis_speculated), 64'd1);
    cycle();

    // Flush with pending replays.
    clr(); i_flush = 1;
    cycle();
    for (int i = 0; i < 4; i++) alloc(20 + i, 32'h0000_0400 + 32'(i), 2'd0);
    for (int i = 0; i < 4; i++) begin
      clr(); i_update_en = 1; i_update_slot = SW'(i); i_update_retry = 1;
      cycle();
    end
    clr(); i_mhq_fill_en = 1; i_mhq_fill_tag = 2'd2;
    cycle();
    clr();
    chk("pending_valid", 64'(o_replay_valid), 64'd1);
    chk("pending_count", 64'(o_count), 64'd4);
    i_flush = 1;
    cycle();
    clr();
    chk("flush_empty", 64'(o_empty), 64'd1);
    chk("flush_replay", 64'(o_replay_valid), 64'd0);

    // Asynchronous reset during a stalled replay.
    alloc(30, 32'h0000_0500, 2'd1);
    alloc(31, 32'h0000_0510, 2'd1);
    clr(); i_update_en = 1; i_update_slot = 3'd1; i_update_retry = 1; i_mhq_fill_en = 1;
    cycle();
    clr();
    chk("pre_rst_valid", 64'(o_replay_valid), 64'd1);
    #2 rst = 1;
    #1;
    chk("async_empty", 64'(o_empty), 64'd1);
    chk("async_count", 64'(o_count), 64'd0);
    chk("async_full", 64'(o_full), 64'd0);
    chk("async_replay_valid", 64'(o_replay_valid), 64'd0);
    chk("async_replay_slot", 64'(o_replay_slot), 64'd0);
    chk("async_replay_tag", 64'(o_replay_tag), 64'd0);
    chk("async_replay_addr", 64'(o_replay_addr), 64'd0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      clr();
      i_flush          = ($urandom_range(0, 99) == 0);
      i_alloc_en       = ($urandom_range(0, 2) != 0);
      i_alloc_tag      = fresh_tag();
      i_alloc_addr     = rand_addr();
      i_alloc_size     = 2'($urandom_range(0, 3));
      i_replay_ready   = ($urandom_range(0, 2) != 0);
      i_update_en      = ($urandom_range(0, 2) == 0);
      i_update_slot    = SW'($urandom_range(0, D - 1));
      i_update_retry   = ($urandom_range(0, 3) == 0);
      i_update_mhq_tag = MW'($urandom_range(0, 3));
      i_mhq_fill_en    = ($urandom_range(0, 2) == 0);
      i_mhq_fill_tag   = MW'($urandom_range(0, 3));
      i_sq_retire_en   = ($urandom_range(0, 3) == 0);
      i_sq_retire_addr = rand_addr();
      i_sq_retire_size = 2'($urandom_range(0, 3));
      i_rob_retire_en  = ($urandom_range(0, 3) == 0);
      s = int'($urandom_range(0, D - 1));
      i_rob_retire_tag = (m_valid[s] && $urandom_range(0, 3) != 0) ? m_tag[s] : TW'($urandom_range(0, 63));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
